// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encodings,
// the flag bundle, and the op-decode helpers used on the input side.
package addsub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic opInvertB(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  // ADD and SUB fix the carry-in; ADC and SBC take it from the port.
  function automatic logic opCarryIn(input logic [1:0] op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_SUB:  c = 1'b1;
      default: c = cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the split carry chain plus its pipeline register.
// Operands and already-resolved result slices ride along at full width.
module addsub_stage #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
  input  logic             zero_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             msbCarry_o
);

  localparam int LO = IDX * CHUNK;

  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic [CHUNK:0]   sliceSum;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             msbCarry_d, msbCarry_q;

  // Carry into the slice MSB is recovered from the sum bit, so the last
  // stage can form signed overflow without a second adder.
  always_comb begin
    sliceA     = a_i[LO +: CHUNK];
    sliceB     = b_i[LO +: CHUNK];
    sliceSum   = {1'b0, sliceA} + {1'b0, sliceB} + (CHUNK + 1)'(carry_i);
    valid_d    = valid_i;
    a_d        = a_i;
    b_d        = b_i;
    sum_d      = sum_i;
    sum_d[LO +: CHUNK] = sliceSum[CHUNK-1:0];
    carry_d    = sliceSum[CHUNK];
    zero_d     = zero_i & (sliceSum[CHUNK-1:0] == '0);
    msbCarry_d = sliceSum[CHUNK-1] ^ sliceA[CHUNK-1] ^ sliceB[CHUNK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      msbCarry_q <= 1'b0;
    end else if (en_i) begin
      valid_q    <= valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      msbCarry_q <= msbCarry_d;
    end
  end

  assign valid_o    = valid_q;
  assign a_o        = a_q;
  assign b_o        = b_q;
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign zero_o     = zero_q;
  assign msbCarry_o = msbCarry_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract with N/Z/C/V flags: one CHUNK-bit carry slice per
// stage, valid/ready handshake, whole-pipe stall on output backpressure.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] aPipe   [0:STAGES];
  logic [WIDTH-1:0] bPipe   [0:STAGES];
  logic [WIDTH-1:0] sumPipe [0:STAGES];
  logic [STAGES:0]  validPipe;
  logic [STAGES:0]  carryPipe;
  logic [STAGES:0]  zeroPipe;
  logic [STAGES-1:0] msbCarry;
  flags_t           flags;
  logic             unusedBits;

  // The whole pipe moves as one; a held output freezes every stage.
  assign advance  = ~validPipe[STAGES] | out_ready;
  assign in_ready = advance;

  assign validPipe[0] = in_valid;
  assign aPipe[0]     = a;
  assign bPipe[0]     = opInvertB(op) ? ~b : b;
  assign sumPipe[0]   = '0;
  assign carryPipe[0] = opCarryIn(op, cin);
  assign zeroPipe[0]  = 1'b1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (advance),
      .valid_i    (validPipe[k]),
      .a_i        (aPipe[k]),
      .b_i        (bPipe[k]),
      .sum_i      (sumPipe[k]),
      .carry_i    (carryPipe[k]),
      .zero_i     (zeroPipe[k]),
      .valid_o    (validPipe[k+1]),
      .a_o        (aPipe[k+1]),
      .b_o        (bPipe[k+1]),
      .sum_o      (sumPipe[k+1]),
      .carry_o    (carryPipe[k+1]),
      .zero_o     (zeroPipe[k+1]),
      .msbCarry_o (msbCarry[k])
    );
  end

  assign flags.n = sumPipe[STAGES][WIDTH-1];
  assign flags.z = zeroPipe[STAGES];
  assign flags.c = carryPipe[STAGES];
  assign flags.v = msbCarry[STAGES-1] ^ carryPipe[STAGES];

  assign out_valid = validPipe[STAGES];
  assign result    = sumPipe[STAGES];
  assign flag_n    = flags.n;
  assign flag_z    = flags.z;
  assign flag_c    = flags.c;
  assign flag_v    = flags.v;

  // Operands leaving the last stage and inner-slice MSB carries have no consumer.
  assign unusedBits = ^{aPipe[STAGES], bPipe[STAGES], msbCarry};

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: directed vector table, back-to-back/stall and
// mid-stream reset sequences, and random traffic on three configurations.
module tb_addsub_pipe;
  import addsub_pkg::*;

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] expResult;
    logic [3:0]  expNzcv;
  } vec_t;

  typedef struct packed {
    logic [63:0] result;
    logic [3:0]  nzcv;
  } expect_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;

  logic        inReady, outValid;
  logic [63:0] result;
  logic [3:0]  flags;
  logic        inReady32, outValid32;
  logic [31:0] result32;
  logic [3:0]  flags32;
  logic        inReadyS, outValidS;
  logic [63:0] resultS;
  logic [3:0]  flagsS;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(64), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(outValid), .out_ready(outReady), .result(result),
    .flag_n(flags[3]), .flag_z(flags[2]), .flag_c(flags[1]), .flag_v(flags[0])
  );

  addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady32),
    .a(a[31:0]), .b(b[31:0]), .op(op), .cin(cin),
    .out_valid(outValid32), .out_ready(outReady), .result(result32),
    .flag_n(flags32[3]), .flag_z(flags32[2]), .flag_c(flags32[1]), .flag_v(flags32[0])
  );

  addsub_pipe #(.WIDTH(64), .CHUNK(64)) dutS (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReadyS),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(outValidS), .out_ready(outReady), .result(resultS),
    .flag_n(flagsS[3]), .flag_z(flagsS[2]), .flag_c(flagsS[1]), .flag_v(flagsS[0])
  );

  // Reference: one wide addition on the effective operands, flags from the sum.
  function automatic expect_t model(input int w, input logic [1:0] o,
                                    input logic [63:0] x, input logic [63:0] y,
                                    input logic ci);
    logic [64:0] s;
    logic [63:0] mask, xm, ym;
    logic        c0;
    expect_t     e;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    ym   = ((o == OP_SUB || o == OP_SBC) ? ~y : y) & mask;
    c0   = (o == OP_ADD) ? 1'b0 : (o == OP_SUB) ? 1'b1 : ci;
    s    = {1'b0, xm} + {1'b0, ym} + {64'd0, c0};
    e.result  = s[63:0] & mask;
    e.nzcv[3] = e.result[w-1];
    e.nzcv[2] = (e.result == 64'd0);
    e.nzcv[1] = s[w];
    e.nzcv[0] = (xm[w-1] == ym[w-1]) && (e.result[w-1] != xm[w-1]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one op, then count clock edges until it appears at the output.
  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    outReady = 1'b1;
    inValid  = 1'b1;
    op = v.op; a = v.a; b = v.b; cin = v.cin;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    inValid = 1'b0;
    while (!outValid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  vec_t    vecs [13];
  expect_t q64[$], q32[$], qS[$];
  expect_t e;
  int      lat;

  initial begin
    vecs[0]  = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[1]  = '{OP_SUB, 64'd5, 64'd5, 1'b0, 64'd0, 4'b0110};
    vecs[2]  = '{OP_SUB, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[3]  = '{OP_ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 4'b0110};
    vecs[4]  = '{OP_SBC, 64'd10, 64'd3, 1'b0, 64'd6, 4'b0010};
    vecs[5]  = '{OP_ADD, 64'd0, 64'd0, 1'b0, 64'd0, 4'b0100};
    vecs[6]  = '{OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[7]  = '{OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1010};
    vecs[8]  = '{OP_ADC, 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b0, 64'h0000_FFFF_0001_0000, 4'b0000};
    vecs[9]  = '{OP_SBC, 64'd5, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    vecs[10] = '{OP_SUB, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[11] = '{OP_ADD, 64'd1, 64'd2, 1'b1, 64'd3, 4'b0000};
    vecs[12] = '{OP_SUB, 64'd7, 64'd2, 1'b0, 64'd5, 4'b0010};

    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    op = OP_ADD; a = 64'd0; b = 64'd0; cin = 1'b0;
    #3;
    checkOutput("reset out_valid", 128'(outValid), 128'(1'b0));
    checkOutput("reset result", 128'(result), 128'(64'd0));
    checkOutput("reset flags", 128'(flags), 128'(4'b0000));
    checkOutput("reset in_ready", 128'(inReady), 128'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'(4));
      checkOutput($sformatf("vec%0d result", i), 128'(result), 128'(vecs[i].expResult));
      checkOutput($sformatf("vec%0d nzcv", i), 128'(flags), 128'(vecs[i].expNzcv));
    end

    // Back-to-back stream of 14 ops with a 3-cycle output stall in the middle.
    begin
      logic [63:0] opA[14], opB[14];
      int          outCycle[$];
      int          idx = 0, received = 0;
      logic        ok;
      for (int j = 0; j < 14; j++) begin
        opA[j] = 64'h0123_4567_89AB_CDEF * 64'(j + 1);
        opB[j] = 64'hF0F0_0000_1234_8888 ^ 64'(j * 977);
      end
      q64.delete();
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        outReady = !(cyc >= 12 && cyc < 15);
        #1;
        if (outValid && outReady) begin
          if (q64.size() == 0) checkOutput("b2b spurious", 128'(1), 128'(0));
          else begin
            e = q64.pop_front();
            checkOutput("b2b output", 128'({result, flags}), 128'({e.result, e.nzcv}));
          end
          outCycle.push_back(cyc);
          received++;
        end
        if (!outReady) begin
          checkOutput("stall in_ready", 128'(inReady), 128'(1'b0));
          if (q64.size() == 0) checkOutput("stall queue", 128'(0), 128'(1));
          else checkOutput("stall hold", 128'({outValid, result, flags}),
                           128'({1'b1, q64[0].result, q64[0].nzcv}));
        end
        if (idx < 14) begin
          inValid = 1'b1;
          if (inReady) begin
            op = 2'(idx % 4); a = opA[idx]; b = opB[idx]; cin = idx[0];
            q64.push_back(model(64, op, a, b, cin));
            idx++;
          end else begin
            op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            cin = 1'($urandom);
          end
        end else begin
          inValid = 1'b0;
        end
      end
      checkOutput("b2b count", 128'(received), 128'(14));
      ok = (outCycle.size() >= 8);
      if (ok) begin
        ok = (outCycle[0] == 4);
        for (int i = 1; i < 8; i++) ok &= (outCycle[i] == outCycle[i-1] + 1);
      end
      checkOutput("b2b consecutive", 128'(ok), 128'(1'b1));
    end

    // Asynchronous reset with three ops in flight, the oldest held at the output.
    begin
      logic stale = 1'b0;
      @(negedge clk);
      outReady = 1'b0; inValid = 1'b1;
      op = OP_ADD; a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0;
      @(negedge clk);
      op = OP_SUB; a = 64'd5; b = 64'd5;
      @(negedge clk);
      op = OP_ADC; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd0; cin = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      @(negedge clk);
      checkOutput("pre-reset out_valid", 128'(outValid), 128'(1'b1));
      checkOutput("pre-reset result", 128'(result), 128'(64'h8000_0000_0000_0000));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid-reset out_valid", 128'(outValid), 128'(1'b0));
      checkOutput("mid-reset result", 128'(result), 128'(64'd0));
      checkOutput("mid-reset flags", 128'(flags), 128'(4'b0000));
      checkOutput("mid-reset in_ready", 128'(inReady), 128'(1'b1));
      @(negedge clk);
      rst_n = 1'b1; outReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (outValid) stale = 1'b1;
      end
      checkOutput("no stale output", 128'(stale), 128'(1'b0));
      applyStimulus(vecs[4], lat);
      checkOutput("post-reset latency", 128'(lat), 128'(4));
      checkOutput("post-reset result", 128'({result, flags}),
                  128'({vecs[4].expResult, vecs[4].expNzcv}));
    end

    // Random traffic with bubbles on all three configurations at once.
    @(negedge clk);
    rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    q64.delete(); q32.delete(); qS.delete();
    for (int cyc = 0; cyc < 310; cyc++) begin
      @(negedge clk);
      #1;
      if (outValid) begin
        if (q64.size() == 0) checkOutput("rnd64 spurious", 128'(1), 128'(0));
        else begin
          e = q64.pop_front();
          checkOutput("rnd64", 128'({result, flags}), 128'({e.result, e.nzcv}));
        end
      end
      if (outValid32) begin
        if (q32.size() == 0) checkOutput("rnd32 spurious", 128'(1), 128'(0));
        else begin
          e = q32.pop_front();
          checkOutput("rnd32", 128'({32'd0, result32, flags32}), 128'({e.result, e.nzcv}));
        end
      end
      if (outValidS) begin
        if (qS.size() == 0) checkOutput("rnd1stage spurious", 128'(1), 128'(0));
        else begin
          e = qS.pop_front();
          checkOutput("rnd1stage", 128'({resultS, flagsS}), 128'({e.result, e.nzcv}));
        end
      end
      inValid = (cyc < 300) && ($urandom_range(0, 3) != 0);
      op  = 2'($urandom);
      cin = 1'($urandom);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      if (inValid) begin
        q64.push_back(model(64, op, a, b, cin));
        q32.push_back(model(32, op, a, b, cin));
        qS.push_back(model(64, op, a, b, cin));
      end
    end
    checkOutput("rnd64 drained", 128'(q64.size()), 128'(0));
    checkOutput("rnd32 drained", 128'(q32.size()), 128'(0));
    checkOutput("rnd1stage drained", 128'(qS.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
